// File: rtl/me_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : me_frame_scheduler
//  Description : Frame-level sequencer for the motion-estimation controller.
//                Walks the macroblock raster, runs one four-phase req/ack
//                search per block, queues each block's result in a small
//                first-word-fall-through FIFO and accumulates the frame SAD.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    start               begin a frame (only honoured while idle)
//    busy, done          frame in progress / one-cycle end-of-frame pulse
//    mb_x, mb_y          current block position, to the window loaders
//    me_req, me_ack      four-phase handshake with the controller
//    me_min_mvec/sad     controller result, captured on the ack edge
//    res_valid/ready     result FIFO head handshake (pop on valid & ready)
//    res_mb_x/y, res_mvec, res_sad   FIFO head entry
//    frame_sad           running sum of captured SADs
// ============================================================================
module me_frame_scheduler #(
    parameter int MB_COLS    = 4,
    parameter int MB_ROWS    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [5:0]  mb_x,
    output logic [5:0]  mb_y,
    output logic        me_req,
    input  logic        me_ack,
    input  logic [11:0] me_min_mvec,
    input  logic [15:0] me_min_sad,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_mb_x,
    output logic [5:0]  res_mb_y,
    output logic [11:0] res_mvec,
    output logic [15:0] res_sad,
    output logic [27:0] frame_sad
);

    localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [5:0]      C_LAST_X = 6'(MB_COLS - 1);
    localparam logic [5:0]      C_LAST_Y = 6'(MB_ROWS - 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_ISSUE        = 3'd1;
    localparam logic [2:0] S_WAIT_ACK     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK_LOW = 3'd3;
    localparam logic [2:0] S_ADVANCE      = 3'd4;
    localparam logic [2:0] S_DRAIN        = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [5:0]       r_mb_x;
    logic [5:0]       r_mb_y;
    logic             r_me_req;
    logic             r_busy;
    logic [27:0]      r_frame_sad;
    logic [39:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_room;
    logic w_last_x;
    logic w_last_y;
    logic w_start_frame;
    logic w_issue_go;
    logic w_push;
    logic w_advance;
    logic w_done;

    assign w_pop    = (r_count != '0) && res_ready;
    // Space is judged on the registered count only; a pop in the same cycle
    // frees the slot one edge later.
    assign w_room   = (r_count < C_DEPTH);
    assign w_last_x = (r_mb_x == C_LAST_X);
    assign w_last_y = (r_mb_y == C_LAST_Y);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         if (start) w_state_nxt = S_ISSUE;
            S_ISSUE:        if (w_room) w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:     if (me_ack) w_state_nxt = S_WAIT_ACK_LOW;
            S_WAIT_ACK_LOW: if (!me_ack) w_state_nxt = S_ADVANCE;
            S_ADVANCE:      w_state_nxt = (w_last_x && w_last_y) ? S_DRAIN : S_ISSUE;
            S_DRAIN:        if (w_done) w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_start_frame = 1'b0;
        w_issue_go    = 1'b0;
        w_push        = 1'b0;
        w_advance     = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE:     w_start_frame = start;
            S_ISSUE:    w_issue_go    = w_room;
            S_WAIT_ACK: w_push        = me_ack;
            S_ADVANCE:  w_advance     = 1'b1;
            // The frame ends as soon as the FIFO is (or is being made) empty.
            S_DRAIN:    w_done = (r_count == '0) ||
                                 ((r_count == CNT_W'(1)) && w_pop);
            default:    w_done = 1'b0;
        endcase
    end

    // ---------------- datapath and FIFO control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mb_x      <= '0;
            r_mb_y      <= '0;
            r_me_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_sad <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_start_frame) begin
                r_mb_x      <= '0;
                r_mb_y      <= '0;
                r_frame_sad <= '0;
                r_busy      <= 1'b1;
            end
            if (w_issue_go) begin
                r_me_req <= 1'b1;
            end
            if (w_push) begin
                r_me_req    <= 1'b0;
                r_frame_sad <= r_frame_sad + {12'd0, me_min_sad};
                r_wr_ptr    <= r_wr_ptr + 1'b1;
            end
            if (w_advance) begin
                if (w_last_x) begin
                    r_mb_x <= '0;
                    if (!w_last_y) begin
                        r_mb_y <= r_mb_y + 6'd1;
                    end
                end else begin
                    r_mb_x <= r_mb_x + 6'd1;
                end
            end
            if (w_done) begin
                r_busy <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Result storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_mb_x, r_mb_y, me_min_mvec, me_min_sad};
        end
    end

    assign busy      = r_busy;
    assign done      = w_done;
    assign mb_x      = r_mb_x;
    assign mb_y      = r_mb_y;
    assign me_req    = r_me_req;
    assign frame_sad = r_frame_sad;
    assign res_valid = (r_count != '0);
    assign res_mb_x  = r_mem[r_rd_ptr][39:34];
    assign res_mb_y  = r_mem[r_rd_ptr][33:28];
    assign res_mvec  = r_mem[r_rd_ptr][27:16];
    assign res_sad   = r_mem[r_rd_ptr][15:0];

endmodule
`default_nettype wire
